// File: rtl/ucsbece154b_issue_queue.sv
// Dual-issue fetch/decode instruction queue: circular buffer of {pc, instr} presenting the two oldest entries.
// Optional ISSUE_QUEUE_BYPASS_EN: an empty queue forwards fetched instructions to decode in the same cycle.
module ucsbece154b_issue_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid_i,
  input  logic            fetch_valid2_i,
  input  logic [XLEN-1:0] fetch_instr1_i,
  input  logic [XLEN-1:0] fetch_instr2_i,
  input  logic [XLEN-1:0] fetch_pc1_i,
  input  logic [XLEN-1:0] fetch_pc2_i,
  output logic            fetch_ready_o,
  input  logic            StallD_i,
  input  logic            SplitD_i,
  input  logic            FlushD_i,
  output logic [XLEN-1:0] InstrD_o1,
  output logic [XLEN-1:0] InstrD_o2,
  output logic [XLEN-1:0] PCD_o1,
  output logic [XLEN-1:0] PCD_o2,
  output logic            ValidD_o1,
  output logic            ValidD_o2
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0]  r_pc    [DEPTH];
  logic [XLEN-1:0]  r_instr [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;

  logic             w_enq;
  logic [1:0]       w_enq_n;
  logic [1:0]       w_deq;
  logic [CNT_W-1:0] w_avail;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;

  assign fetch_ready_o = r_ready;
  assign w_head1       = r_head + PTR_W'(1);
  assign w_tail1       = r_tail + PTR_W'(1);

  // Wrong-path fetch during a flush is dropped; reset also blocks writes.
  assign w_enq   = fetch_valid_i & r_ready & ~FlushD_i & reset;
  assign w_enq_n = w_enq ? (fetch_valid2_i ? 2'd2 : 2'd1) : 2'd0;

`ifdef ISSUE_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_enq & (r_count == '0);
  // Bypassed instructions are dequeue candidates in the cycle they arrive.
  assign w_avail  = w_bypass ? CNT_W'(w_enq_n) : r_count;
`else
  assign w_avail  = r_count;
`endif

  // Dequeue amount; stall wins over split, flush is handled in the register block.
  always_comb begin
    w_deq = 2'd0;
    if (StallD_i) begin
      w_deq = 2'd0;
    end else if (SplitD_i) begin
      w_deq = (w_avail != '0) ? 2'd1 : 2'd0;
    end else if (w_avail >= CNT_W'(2)) begin
      w_deq = 2'd2;
    end else begin
      w_deq = w_avail[1:0];
    end
  end

  assign w_count_next = r_count + CNT_W'(w_enq_n) - CNT_W'(w_deq);

  // Pointer, count and ready registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else if (FlushD_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_enq_n);
      r_count <= w_count_next;
      r_ready <= (w_count_next <= CNT_W'(DEPTH - 2));
    end
  end

  // Entry storage; contents are only observed through the valid-gated slots.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc[r_tail]    <= fetch_pc1_i;
      r_instr[r_tail] <= fetch_instr1_i;
      if (fetch_valid2_i) begin
        r_pc[w_tail1]    <= fetch_pc2_i;
        r_instr[w_tail1] <= fetch_instr2_i;
      end
    end
  end

  // Decode slots; empty slots carry a NOP at PC 0.
  always_comb begin
    ValidD_o1 = 1'b0;
    ValidD_o2 = 1'b0;
    InstrD_o1 = NOP;
    InstrD_o2 = NOP;
    PCD_o1    = '0;
    PCD_o2    = '0;
`ifdef ISSUE_QUEUE_BYPASS_EN
    if (w_bypass) begin
      ValidD_o1 = 1'b1;
      InstrD_o1 = fetch_instr1_i;
      PCD_o1    = fetch_pc1_i;
      if (fetch_valid2_i) begin
        ValidD_o2 = 1'b1;
        InstrD_o2 = fetch_instr2_i;
        PCD_o2    = fetch_pc2_i;
      end
    end else begin
`else
    begin
`endif
      if (r_count >= CNT_W'(1)) begin
        ValidD_o1 = 1'b1;
        InstrD_o1 = r_instr[r_head];
        PCD_o1    = r_pc[r_head];
      end
      if (r_count >= CNT_W'(2)) begin
        ValidD_o2 = 1'b1;
        InstrD_o2 = r_instr[w_head1];
        PCD_o2    = r_pc[w_head1];
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154b_issue_queue.sv
// Directed bench for ucsbece154b_issue_queue (DEPTH=8, default build without bypass).
module tb_ucsbece154b_issue_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        fetch_valid_i, fetch_valid2_i;
  logic [31:0] fetch_instr1_i, fetch_instr2_i, fetch_pc1_i, fetch_pc2_i;
  logic        fetch_ready_o;
  logic        StallD_i, SplitD_i, FlushD_i;
  logic [31:0] InstrD_o1, InstrD_o2, PCD_o1, PCD_o2;
  logic        ValidD_o1, ValidD_o2;

  int total = 0;
  int bad   = 0;

  ucsbece154b_issue_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid_i(fetch_valid_i), .fetch_valid2_i(fetch_valid2_i),
    .fetch_instr1_i(fetch_instr1_i), .fetch_instr2_i(fetch_instr2_i),
    .fetch_pc1_i(fetch_pc1_i), .fetch_pc2_i(fetch_pc2_i),
    .fetch_ready_o(fetch_ready_o),
    .StallD_i(StallD_i), .SplitD_i(SplitD_i), .FlushD_i(FlushD_i),
    .InstrD_o1(InstrD_o1), .InstrD_o2(InstrD_o2),
    .PCD_o1(PCD_o1), .PCD_o2(PCD_o2),
    .ValidD_o1(ValidD_o1), .ValidD_o2(ValidD_o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] p);
    return 32'hABCD_0000 | p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic v, input logic v2, input logic [31:0] p1, input logic [31:0] p2);
    fetch_valid_i  = v;
    fetch_valid2_i = v2;
    fetch_pc1_i    = p1;
    fetch_pc2_i    = p2;
    fetch_instr1_i = ins(p1);
    fetch_instr2_i = ins(p2);
  endtask

  task automatic slots(input string tag, input logic v1, input logic [31:0] p1,
                       input logic v2, input logic [31:0] p2);
    chk({tag, ".v1"}, 32'(ValidD_o1), 32'(v1));
    chk({tag, ".pc1"}, PCD_o1, v1 ? p1 : 32'h0);
    chk({tag, ".in1"}, InstrD_o1, v1 ? ins(p1) : NOP);
    chk({tag, ".v2"}, 32'(ValidD_o2), 32'(v2));
    chk({tag, ".pc2"}, PCD_o2, v2 ? p2 : 32'h0);
    chk({tag, ".in2"}, InstrD_o2, v2 ? ins(p2) : NOP);
  endtask

  initial begin
    reset = 1'b0;
    StallD_i = 1'b0; SplitD_i = 1'b0; FlushD_i = 1'b0;
    fetch(1'b0, 1'b0, 32'h0, 32'h0);

    // reset held two cycles
    step(); step();
    chk("rst.ready", 32'(fetch_ready_o), 32'd0);
    slots("rst", 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    step();
    chk("rst.ready_after", 32'(fetch_ready_o), 32'd1);
    slots("rst_after", 1'b0, 32'h0, 1'b0, 32'h0);

    // pair enqueue, one-cycle latency, then drained
    fetch(1'b1, 1'b1, 32'h0, 32'h4);
    step();
    slots("pair", 1'b1, 32'h0, 1'b1, 32'h4);
    fetch(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    slots("pair_drain", 1'b0, 32'h0, 1'b0, 32'h0);

    // split: queue 0x10,0x14,0x18
    StallD_i = 1'b1;
    fetch(1'b1, 1'b1, 32'h10, 32'h14);
    step();
    fetch(1'b1, 1'b0, 32'h18, 32'h0);
    step();
    fetch(1'b0, 1'b0, 32'h0, 32'h0);
    slots("split_pre", 1'b1, 32'h10, 1'b1, 32'h14);
    StallD_i = 1'b0;
    SplitD_i = 1'b1;
    step();
    slots("split", 1'b1, 32'h14, 1'b1, 32'h18);
    SplitD_i = 1'b0;
    step();
    slots("split_drain", 1'b0, 32'h0, 1'b0, 32'h0);

    // stall with streaming fetch until full at 7 (head=5, wraps past entry 7)
    StallD_i = 1'b1;
    fetch(1'b1, 1'b0, 32'h100, 32'h0);
    step();
    fetch(1'b1, 1'b1, 32'h104, 32'h108);
    step();
    fetch(1'b1, 1'b1, 32'h10C, 32'h110);
    step();
    chk("stream.ready5", 32'(fetch_ready_o), 32'd1);
    fetch(1'b1, 1'b1, 32'h114, 32'h118);
    step();
    chk("stream.ready7", 32'(fetch_ready_o), 32'd0);
    slots("stream7", 1'b1, 32'h100, 1'b1, 32'h104);
    fetch(1'b1, 1'b1, 32'h11C, 32'h120);
    step();
    chk("stream.ready_hold", 32'(fetch_ready_o), 32'd0);
    slots("stall_hold", 1'b1, 32'h100, 1'b1, 32'h104);
    StallD_i = 1'b0;
    fetch(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    slots("drain1", 1'b1, 32'h108, 1'b1, 32'h10C);
    chk("drain.ready", 32'(fetch_ready_o), 32'd1);
    step();
    slots("drain2", 1'b1, 32'h110, 1'b1, 32'h114);
    step();
    slots("drain3", 1'b1, 32'h118, 1'b0, 32'h0);
    step();
    slots("drain4", 1'b0, 32'h0, 1'b0, 32'h0);

    // flush with six queued and a wrong-path fetch in the same cycle
    StallD_i = 1'b1;
    fetch(1'b1, 1'b1, 32'h200, 32'h204);
    step();
    fetch(1'b1, 1'b1, 32'h208, 32'h20C);
    step();
    fetch(1'b1, 1'b1, 32'h210, 32'h214);
    step();
    chk("flush.ready6", 32'(fetch_ready_o), 32'd1);
    slots("flush_pre", 1'b1, 32'h200, 1'b1, 32'h204);
    StallD_i = 1'b0;
    FlushD_i = 1'b1;
    fetch(1'b1, 1'b1, 32'h300, 32'h304);
    step();
    slots("flush", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("flush.ready", 32'(fetch_ready_o), 32'd1);
    FlushD_i = 1'b0;
    fetch(1'b1, 1'b1, 32'h400, 32'h404);
    step();
    slots("redirect", 1'b1, 32'h400, 1'b1, 32'h404);
    fetch(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    slots("redirect_drain", 1'b0, 32'h0, 1'b0, 32'h0);

    // single-instruction fetch into empty queue
    fetch(1'b1, 1'b0, 32'h500, 32'h0);
    step();
    slots("single", 1'b1, 32'h500, 1'b0, 32'h0);
    fetch(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    slots("single_drain", 1'b0, 32'h0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
